dmem_arbiter: RTL and testbench

//  Shares the single-port-per-direction word data memory (memoryData) between two

---
 rtl/dmem_arbiter.sv | 120 ++++++++++++
 tb/tb_dmem_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port (core C, DMA/debug D) arbiter in front of the word data memory: sequences loads
// against the 1-cycle registered read and does read-modify-write for partial-byte stores.
module dmem_arbiter #(
  parameter int PRIO_MODE = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        c_req_valid,
  output logic        c_req_ready,
  input  logic        c_req_we,
  input  logic [31:0] c_req_addr,
  input  logic [31:0] c_req_wdata,
  input  logic [3:0]  c_req_be,
  output logic        c_rsp_valid,
  output logic [31:0] c_rsp_rdata,
  input  logic        d_req_valid,
  output logic        d_req_ready,
  input  logic        d_req_we,
  input  logic [31:0] d_req_addr,
  input  logic [31:0] d_req_wdata,
  input  logic [3:0]  d_req_be,
  output logic        d_rsp_valid,
  output logic [31:0] d_rsp_rdata,
  output logic [31:0] mem_read_addr,
  input  logic [31:0] mem_read_data,
  output logic [31:0] mem_write_addr,
  output logic [31:0] mem_write_data,
  output logic        mem_write_enable
);

  typedef enum logic [1:0] {IDLE, ISSUE, RD_WAIT, RMW_WAIT} state_t;

  state_t      state;
  logic        owner_d;
  logic        last_d;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;

  logic        grant_c;
  logic        grant_d;
  logic        accept;
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [3:0]  sel_be;
  logic        whole_word;
  logic        done;
  logic [31:0] lane_mask;

  // last_d set means D was granted most recently, so C wins the next tie.
  always_comb begin
    grant_c = c_req_valid && (!d_req_valid || (PRIO_MODE != 0) || last_d);
    grant_d = d_req_valid && !grant_c;
  end

  assign c_req_ready = (state == IDLE) && !rst && grant_c;
  assign d_req_ready = (state == IDLE) && !rst && grant_d;
  assign accept      = c_req_ready || d_req_ready;

  assign sel_we    = grant_d ? d_req_we    : c_req_we;
  assign sel_addr  = grant_d ? d_req_addr  : c_req_addr;
  assign sel_wdata = grant_d ? d_req_wdata : c_req_wdata;
  assign sel_be    = grant_d ? d_req_be    : c_req_be;

  assign whole_word = (be_q == 4'hF) || (be_q == 4'h0);

  assign done = !rst && (((state == ISSUE) && we_q && whole_word) ||
                         (state == RD_WAIT) || (state == RMW_WAIT));

  assign c_rsp_valid = done && !owner_d;
  assign d_rsp_valid = done && owner_d;
  assign c_rsp_rdata = mem_read_data;
  assign d_rsp_rdata = mem_read_data;

  assign lane_mask = {{8{be_q[3]}}, {8{be_q[2]}}, {8{be_q[1]}}, {8{be_q[0]}}};

  assign mem_read_addr    = addr_q;
  assign mem_write_addr   = addr_q;
  assign mem_write_data   = (state == RMW_WAIT) ?
                            ((wdata_q & lane_mask) | (mem_read_data & ~lane_mask)) : wdata_q;
  assign mem_write_enable = !rst && (((state == ISSUE) && we_q && (be_q == 4'hF)) ||
                                     (state == RMW_WAIT));

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      owner_d <= 1'b0;
      last_d  <= 1'b1;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      be_q    <= 4'h0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            owner_d <= grant_d;
            last_d  <= grant_d;
            we_q    <= sel_we;
            addr_q  <= sel_addr & 32'hFFFF_FFFC;
            wdata_q <= sel_wdata;
            be_q    <= sel_be;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          if (!we_q)           state <= RD_WAIT;
          else if (whole_word) state <= IDLE;
          else                 state <= RMW_WAIT;
        end
        RD_WAIT:  state <= IDLE;
        RMW_WAIT: state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: word memory stand-in, transaction-level reference model checked
// every cycle, and directed scenarios with literal expectations.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        c_req_valid = 1'b0, c_req_we = 1'b0, d_req_valid = 1'b0, d_req_we = 1'b0;
  logic [31:0] c_req_addr = '0, c_req_wdata = '0, d_req_addr = '0, d_req_wdata = '0;
  logic [3:0]  c_req_be = '0, d_req_be = '0;
  logic        c_req_ready, d_req_ready, c_rsp_valid, d_rsp_valid, mem_write_enable;
  logic [31:0] c_rsp_rdata, d_rsp_rdata, mem_read_addr, mem_write_addr, mem_write_data;
  logic [31:0] mem_read_data;

  // fixed-priority instance, exercised only for grant behaviour
  logic        p_c_valid = 1'b0, p_d_valid = 1'b0;
  logic        p_c_ready, p_d_ready, p_c_rsp, p_d_rsp, p_we;
  logic [31:0] p_c_rdata, p_d_rdata, p_raddr, p_waddr, p_wdata;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_arbiter #(.PRIO_MODE(0)) dut (
    .clk(clk), .rst(rst),
    .c_req_valid(c_req_valid), .c_req_ready(c_req_ready), .c_req_we(c_req_we),
    .c_req_addr(c_req_addr), .c_req_wdata(c_req_wdata), .c_req_be(c_req_be),
    .c_rsp_valid(c_rsp_valid), .c_rsp_rdata(c_rsp_rdata),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_we(d_req_we),
    .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata), .d_req_be(d_req_be),
    .d_rsp_valid(d_rsp_valid), .d_rsp_rdata(d_rsp_rdata),
    .mem_read_addr(mem_read_addr), .mem_read_data(mem_read_data),
    .mem_write_addr(mem_write_addr), .mem_write_data(mem_write_data),
    .mem_write_enable(mem_write_enable)
  );

  dmem_arbiter #(.PRIO_MODE(1)) dut_prio (
    .clk(clk), .rst(rst),
    .c_req_valid(p_c_valid), .c_req_ready(p_c_ready), .c_req_we(1'b0),
    .c_req_addr(32'h10), .c_req_wdata(32'h0), .c_req_be(4'h0),
    .c_rsp_valid(p_c_rsp), .c_rsp_rdata(p_c_rdata),
    .d_req_valid(p_d_valid), .d_req_ready(p_d_ready), .d_req_we(1'b0),
    .d_req_addr(32'h20), .d_req_wdata(32'h0), .d_req_be(4'h0),
    .d_rsp_valid(p_d_rsp), .d_rsp_rdata(p_d_rdata),
    .mem_read_addr(p_raddr), .mem_read_data(32'h0),
    .mem_write_addr(p_waddr), .mem_write_data(p_wdata),
    .mem_write_enable(p_we)
  );

  // memoryData stand-in: registered read, synchronous write, cleared by rst
  logic [31:0] mem [256];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      mem_read_data <= 32'h0;
    end else begin
      if (mem_write_enable) mem[mem_write_addr[9:2]] <= mem_write_data;
      mem_read_data <= mem[mem_read_addr[9:2]];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] m;
    m = 32'h0;
    for (int i = 0; i < 4; i++) if (be[i]) m = m | (32'hFF << (8 * i));
    return (old & ~m) | (wd & m);
  endfunction

  // Reference model: one transaction at a time, response after a fixed number of cycles.
  logic [31:0] ref_mem [256];
  int          m_cnt = 0;
  bit          m_last_d = 1'b1;
  bit          o_d, o_we, gc, gd;
  logic [31:0] o_addr, o_exp;
  logic [3:0]  o_be;

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (rst) begin
        m_cnt = 0;
        m_last_d = 1'b1;
        for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
        chk("rst c_req_ready", c_req_ready, 0);
        chk("rst d_req_ready", d_req_ready, 0);
        chk("rst c_rsp_valid", c_rsp_valid, 0);
        chk("rst d_rsp_valid", d_rsp_valid, 0);
        chk("rst mem_write_enable", mem_write_enable, 0);
      end else if (m_cnt == 0) begin
        gc = c_req_valid && (!d_req_valid || m_last_d);
        gd = d_req_valid && !gc;
        chk("idle c_req_ready", c_req_ready, gc);
        chk("idle d_req_ready", d_req_ready, gd);
        chk("idle c_rsp_valid", c_rsp_valid, 0);
        chk("idle d_rsp_valid", d_rsp_valid, 0);
        chk("idle mem_write_enable", mem_write_enable, 0);
        if (gc || gd) begin
          o_d      = gd;
          m_last_d = gd;
          o_we     = gd ? d_req_we : c_req_we;
          o_addr   = (gd ? d_req_addr : c_req_addr) & 32'hFFFF_FFFC;
          o_be     = gd ? d_req_be : c_req_be;
          if (!o_we) o_exp = ref_mem[o_addr[9:2]];
          else o_exp = merge(ref_mem[o_addr[9:2]], gd ? d_req_wdata : c_req_wdata, o_be);
          m_cnt = (o_we && (o_be == 4'hF || o_be == 4'h0)) ? 1 : 2;
        end
      end else begin
        m_cnt--;
        chk("busy c_req_ready", c_req_ready, 0);
        chk("busy d_req_ready", d_req_ready, 0);
        if (m_cnt == 0) begin
          chk("rsp c_rsp_valid", c_rsp_valid, !o_d);
          chk("rsp d_rsp_valid", d_rsp_valid, o_d);
          if (!o_we) chk("rsp rdata", o_d ? d_rsp_rdata : c_rsp_rdata, o_exp);
          chk("rsp mem_write_enable", mem_write_enable, o_we && (o_be != 4'h0));
          if (o_we && o_be != 4'h0) begin
            chk("mem_write_addr", mem_write_addr, o_addr);
            chk("mem_write_data", mem_write_data, o_exp);
            ref_mem[o_addr[9:2]] = o_exp;
          end
        end else begin
          chk("wait c_rsp_valid", c_rsp_valid, 0);
          chk("wait d_rsp_valid", d_rsp_valid, 0);
          chk("wait mem_write_enable", mem_write_enable, 0);
        end
      end
    end
  end

  // One request on port p (0 = C, 1 = D): hold until accepted, then wait for the response.
  task automatic xfer(input bit p, input bit we, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] be, output logic [31:0] rd, output int lat,
                      output int acc_cyc, output int rsp_cyc);
    bit ok, got;
    @(posedge clk); #1;
    if (p) begin
      d_req_we = we; d_req_addr = a; d_req_wdata = wd; d_req_be = be; d_req_valid = 1'b1;
    end else begin
      c_req_we = we; c_req_addr = a; c_req_wdata = wd; c_req_be = be; c_req_valid = 1'b1;
    end
    ok = 1'b0;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge clk);
      ok = p ? d_req_ready : c_req_ready;
    end
    chk("request accepted", ok, 1);
    acc_cyc = cyc;
    @(posedge clk); #1;
    if (p) d_req_valid = 1'b0; else c_req_valid = 1'b0;
    got = 1'b0; lat = 0; rd = 32'h0; rsp_cyc = 0;
    for (int k = 1; k <= 10 && !got; k++) begin
      @(negedge clk);
      if (p ? d_rsp_valid : c_rsp_valid) begin
        got = 1'b1; lat = k; rd = p ? d_rsp_rdata : c_rsp_rdata; rsp_cyc = cyc;
      end
    end
    chk("response seen", got, 1);
  endtask

  logic [31:0] rd, rd2;
  int lat, lat2, ac, ac2, rc, rc2, nc, nd;
  int ord[$];
  bit got;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // full-word store then load
    xfer(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, rd, lat, ac, rc);
    chk("t1 store latency", lat, 1);
    xfer(0, 0, 32'h10, 32'h0, 4'h0, rd, lat, ac, rc);
    chk("t1 load latency", lat, 2);
    chk("t1 load data", rd, 32'hDEADBEEF);

    // D partial store on an unaligned address, then read back
    xfer(1, 1, 32'h13, 32'h0000AB00, 4'b0010, rd, lat, ac, rc);
    chk("t2 rmw latency", lat, 2);
    xfer(0, 0, 32'h10, 32'h0, 4'h0, rd, lat, ac, rc);
    chk("t2 load data", rd, 32'hDEADABEF);

    // empty byte-enable store leaves memory alone
    xfer(0, 1, 32'h10, 32'hFFFFFFFF, 4'h0, rd, lat, ac, rc);
    chk("t5 empty store latency", lat, 1);
    xfer(0, 0, 32'h10, 32'h0, 4'h0, rd, lat, ac, rc);
    chk("t5 load data", rd, 32'hDEADABEF);

    // D arrives while C's load is in flight
    fork
      xfer(0, 0, 32'h10, 32'h0, 4'h0, rd, lat, ac, rc);
      begin
        @(posedge clk);
        xfer(1, 1, 32'h40, 32'h12345678, 4'hF, rd2, lat2, ac2, rc2);
      end
    join
    chk("t6 C load data", rd, 32'hDEADABEF);
    chk("t6 D accept after C rsp", ac2, rc + 1);
    chk("t6 D store latency", lat2, 1);

    // reset lands in RMW_WAIT
    @(posedge clk); #1;
    c_req_we = 1'b1; c_req_addr = 32'h10; c_req_wdata = 32'h11223344; c_req_be = 4'b0001;
    c_req_valid = 1'b1;
    @(negedge clk);
    chk("t4 accept", c_req_ready, 1);
    @(posedge clk); #1 c_req_valid = 1'b0;
    @(posedge clk); #1 begin rst = 1'b1; c_req_valid = 1'b1; end
    repeat (2) begin
      @(negedge clk);
      chk("t4 ready during rst", c_req_ready, 0);
      chk("t4 write during rst", mem_write_enable, 0);
      chk("t4 rsp during rst", c_rsp_valid, 0);
      @(posedge clk); #1;
    end
    rst = 1'b0; c_req_valid = 1'b0;
    xfer(0, 0, 32'h10, 32'h0, 4'h0, rd, lat, ac, rc);
    chk("t4 load after rst", rd, 32'h0);

    // round-robin with both requesters permanently valid, from a fresh reset
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    c_req_we = 1'b0; c_req_addr = 32'h10; d_req_we = 1'b0; d_req_addr = 32'h20;
    c_req_valid = 1'b1; d_req_valid = 1'b1;
    for (int k = 0; k < 40 && ord.size() < 4; k++) begin
      @(negedge clk);
      if (c_req_ready) ord.push_back(0);
      if (d_req_ready) ord.push_back(1);
    end
    @(posedge clk); #1 begin c_req_valid = 1'b0; d_req_valid = 1'b0; end
    chk("t3 rr accept count", ord.size(), 4);
    for (int i = 0; i < ord.size(); i++) chk("t3 rr order", ord[i], i % 2);
    repeat (4) @(posedge clk);

    // fixed priority: D starves while C stays valid
    #1 begin p_c_valid = 1'b1; p_d_valid = 1'b1; end
    nc = 0; nd = 0;
    repeat (12) begin
      @(negedge clk);
      if (p_c_ready) nc++;
      if (p_d_ready) nd++;
    end
    chk("t3 prio C accepts", nc, 4);
    chk("t3 prio D accepts", nd, 0);
    @(posedge clk); #1 p_c_valid = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 6 && !got; k++) begin
      @(negedge clk);
      got = p_d_ready;
    end
    chk("t3 prio D accepted once C idle", got, 1);
    @(posedge clk); #1 p_d_valid = 1'b0;
    repeat (4) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
